apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Parametrised APB master bridge that turns a valid/ready request stream from the SoC interconnect into APB2/APB3 transfers on up to NB_SLAVES peripheral ports. It decodes the target slave from the address, drives one-hot select, handles wait states and slave errors, and returns a valid/ready response. It sits between the AXI-to-APB conversion stage and the peripheral bus (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC control, debug).

## Interface
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width
- NB_SLAVES, 9, number of slave ports (1..16)
- BASE_ADDR, 32'h1A10_0000, address of slave 0
- SLAVE_SIZE_LOG2, 12, log2 of each slave's window; slave i owns [BASE_ADDR + i<<SLAVE_SIZE_LOG2, +window)
- TIMEOUT_CYCLES, 256, ACCESS cycles before abort (only with timeout compiled in)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_addr  in  APB_ADDR_WIDTH  byte address
- req_wdata  in  APB_DATA_WIDTH  write data
- req_write  in  1  1 = write, 0 = read
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  APB_DATA_WIDTH  read data (0 on writes and errors)
- rsp_err  out  1  slave error, decode error or timeout
- paddr  out  APB_ADDR_WIDTH  APB address (full request address)
- pwdata  out  APB_DATA_WIDTH  APB write data
- pwrite  out  1  APB direction
- psel  out  NB_SLAVES  one-hot select
- penable  out  1  APB enable
- prdata  in  NB_SLAVES*APB_DATA_WIDTH  slave i read data at [i*DW +: DW]
- pready  in  NB_SLAVES  per-slave ready
- pslverr  in  NB_SLAVES  per-slave error
- timeout_o  out  1  one-cycle pulse on timeout abort (tied 0 when timeout compiled out)

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On accept, register addr/wdata/write and decode the index as (req_addr-BASE_ADDR)>>SLAVE_SIZE_LOG2. In range -> SETUP. Below BASE_ADDR or index >= NB_SLAVES -> RESP with rsp_err=1 and no APB activity.
- SETUP: psel[idx]=1, penable=0 for exactly one cycle -> ACCESS.
- ACCESS: psel[idx]=1, penable=1. When pready[idx]=1, capture prdata slice (reads) and pslverr[idx] -> RESP. Otherwise stay (wait state).
- RESP: rsp_valid=1 with data/err stable until rsp_ready; then -> IDLE. req_ready=0 in SETUP/ACCESS/RESP: one outstanding transfer.
- pready/pslverr/prdata of unselected slaves are ignored.
- paddr/pwdata/pwrite hold the registered request from SETUP through ACCESS and stay unchanged in IDLE/RESP.
- Reset values: req_ready=0 while HRESETn low (1 in IDLE after reset); rsp_valid=0, rsp_err=0, rsp_rdata=0, psel=0, penable=0, paddr=0, pwdata=0, pwrite=0, timeout_o=0; FSM=IDLE.
- Reset asserted mid-transfer: psel/penable/rsp_valid drop asynchronously; the in-flight transfer is discarded without a response.

## Timing
- Zero-wait in-range transfer: accept at cycle 0, SETUP cycle 1, ACCESS cycle 2 (pready=1), rsp_valid from cycle 3.
- Each pready-low ACCESS cycle adds one cycle.
- Decode error: accept at cycle 0, rsp_valid with rsp_err=1 from cycle 1.
- Back-to-back: rsp handshake at cycle n -> IDLE at n+1, next accept earliest n+1. Minimum 4 cycles per transfer.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: a counter runs in ACCESS. After TIMEOUT_CYCLES consecutive cycles with pready[idx]=0, psel/penable drop, timeout_o pulses, and RESP is entered with rsp_err=1, rsp_rdata=0. pready arriving in the same cycle as expiry wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely and timeout_o is tied 0.

## Test plan
- Write 0xDEADBEEF to 0x1A10_1004, pready=1 -> psel=9'b000000010 in cycles 1-2, penable only in cycle 2, rsp_valid cycle 3, rsp_err=0.
- Read 0x1A10_3000 with 3 wait states, slave 3 prdata=0x12345678 -> ACCESS lasts 4 cycles, rsp_rdata=0x12345678 at cycle 6.
- Read 0x1A10_9000 (index 9) and 0x1A0F_FFFC -> psel stays 0, rsp_err=1 at cycle 1, rsp_rdata=0.
- pslverr[5]=1 with pready on a write to 0x1A10_5000 -> rsp_err=1; hold rsp_ready=0 for 5 cycles -> response stable, req_ready=0.
- APB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave 2 never ready -> abort after 8 ACCESS cycles, timeout_o pulse, rsp_err=1; without the macro it is still waiting after 1000 cycles.
- HRESETn low during ACCESS -> psel=0, penable=0, rsp_valid=0 immediately; after release the next request completes normally.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: bridges a valid/ready request stream onto an APB bus with
// NB_SLAVES address-decoded peripheral ports. Only one transfer is outstanding
// at a time. Optional ACCESS-phase timeout is compiled in with the macro
// APB_MASTER_TIMEOUT_EN. Without the macro, ACCESS waits indefinitely and
// timeout_o is tied low.
module apb_master_ctrl #(
  parameter int unsigned                      APB_ADDR_WIDTH  = 32,
  parameter int unsigned                      APB_DATA_WIDTH  = 32,
  parameter int unsigned                      NB_SLAVES       = 9,
  parameter logic [APB_ADDR_WIDTH-1:0]        BASE_ADDR       = 'h1A10_0000,
  parameter int unsigned                      SLAVE_SIZE_LOG2 = 12,
  parameter int unsigned                      TIMEOUT_CYCLES  = 256
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [APB_ADDR_WIDTH-1:0]           req_addr,
  input  logic [APB_DATA_WIDTH-1:0]           req_wdata,
  input  logic                                req_write,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [APB_DATA_WIDTH-1:0]           rsp_rdata,
  output logic                                rsp_err,
  output logic [APB_ADDR_WIDTH-1:0]           paddr,
  output logic [APB_DATA_WIDTH-1:0]           pwdata,
  output logic                                pwrite,
  output logic [NB_SLAVES-1:0]                psel,
  output logic                                penable,
  input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] prdata,
  input  logic [NB_SLAVES-1:0]                pready,
  input  logic [NB_SLAVES-1:0]                pslverr,
  output logic                                timeout_o
);

  localparam int unsigned IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [APB_ADDR_WIDTH-1:0] offset;
  logic [APB_ADDR_WIDTH-1:0] slot;
  logic                      in_range;
  logic                      accept;
  logic                      sel_ready;
  logic                      sel_err;
  logic [APB_DATA_WIDTH-1:0] sel_rdata;
  logic                      tmo_expire;

  // Address decode: slot index relative to BASE_ADDR, rejecting addresses below
  // the base or beyond the last slave window.
  assign offset   = req_addr - BASE_ADDR;
  assign slot     = offset >> SLAVE_SIZE_LOG2;
  assign in_range = (req_addr >= BASE_ADDR) && (slot < APB_ADDR_WIDTH'(NB_SLAVES));

  // req_ready is gated by HRESETn so it reads low for the whole reset period.
  assign req_ready = (state_q == IDLE) && HRESETn;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);

  // Only the selected slave's response lines are observed.
  assign sel_ready = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign sel_rdata = prdata[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;

  // Expiry fires on the TIMEOUT_CYCLES-th consecutive not-ready ACCESS cycle;
  // a pready in that same cycle takes precedence.
  assign tmo_expire = (state_q == ACCESS) && !sel_ready &&
                      (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive wait cycles in ACCESS; register the abort pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == ACCESS) && !sel_ready) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
      timeout_q <= tmo_expire;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_expire = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // State register; async reset discards any in-flight transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and APB control outputs (decoded from state so they drop
  // asynchronously with reset).
  always_comb begin
    state_d = state_q;
    psel    = '0;
    penable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_range ? SETUP : RESP;
        end
      end
      SETUP: begin
        psel[idx_q] = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        psel[idx_q] = 1'b1;
        penable     = 1'b1;
        if (sel_ready || tmo_expire) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and response registers. APB address/data only update on an
  // in-range accept, so decode errors leave the bus untouched.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      idx_q     <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        if (in_range) begin
          paddr  <= req_addr;
          pwdata <= req_wdata;
          pwrite <= req_write;
          idx_q  <= slot[IDX_W-1:0];
        end else begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state_q == ACCESS) begin
        if (sel_ready) begin
          rsp_err   <= sel_err;
          rsp_rdata <= (!pwrite && !sel_err) ? sel_rdata : '0;
        end else if (tmo_expire) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: a table of single transfers with
// hand-computed results, plus sequences for stall/timeout and mid-transfer reset.
module tb_apb_master_ctrl;

  localparam int NS = 9;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic              req_write = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic              pwrite;
  logic [NS-1:0]     psel;
  logic              penable;
  logic [NS*DW-1:0]  prdata = '0;
  logic [NS-1:0]     pready = '0;
  logic [NS-1:0]     pslverr = '0;
  logic              timeout_o;

  int checks = 0;
  int failures = 0;

  apb_master_ctrl #(
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .NB_SLAVES      (NS),
    .BASE_ADDR      (32'h1A10_0000),
    .SLAVE_SIZE_LOG2(12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_write(req_write),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pwrite   (pwrite),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .timeout_o(timeout_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    int          waits;     // not-ready ACCESS cycles before pready
    logic [31:0] srdata;    // selected slave's prdata
    logic        slverr;
    int          hold;      // cycles rsp_ready is held low while RESP is shown
    logic [8:0]  exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;   // cycles from accept to first rsp_valid
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Selected slave answers with the given values; every other slave shows
  // ready/error/garbage data, which the master must ignore.
  task automatic set_slaves(input int sidx, input logic rdy, input logic err, input logic [31:0] d);
    for (int i = 0; i < NS; i++) begin
      pready[i]          = (i == sidx) ? rdy : 1'b1;
      pslverr[i]         = (i == sidx) ? err : 1'b1;
      prdata[i*DW +: DW] = (i == sidx) ? d : (32'hBAD0_0000 | 32'(i));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int         sidx = -1;
    int         lat;
    int         nsetup = 0;
    int         nacc = 0;
    logic [8:0] seen = '0;
    bit         done = 0;
    bit         bus_ok = 1;
    bit         hold_ok = 1;
    for (int i = 0; i < NS; i++) if (v.exp_sel[i]) sidx = i;
    check({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_write = v.write;
    rsp_ready = 1'b0;
    set_slaves(sidx, 1'b0, 1'b0, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      if (rsp_valid) begin
        done = 1;
      end else begin
        if (psel != '0) begin
          if (seen == '0) seen = psel;
          if (!penable) nsetup++;
          else nacc++;
          if (paddr !== v.addr || pwrite !== v.write || (v.write && pwdata !== v.wdata)) bus_ok = 0;
          if (penable) set_slaves(sidx, nacc > v.waits, v.slverr, v.srdata);
          else set_slaves(sidx, 1'b0, 1'b0, 32'h0);
        end
        @(negedge HCLK);
        lat++;
      end
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_psel"}, seen, v.exp_sel);
    check({tag, "_setup_cycles"}, nsetup, (v.exp_sel != '0) ? 1 : 0);
    check({tag, "_access_cycles"}, nacc, (v.exp_sel != '0) ? v.waits + 1 : 0);
    check({tag, "_bus_fields"}, bus_ok, 1);
    check({tag, "_rsp_err"}, rsp_err, v.exp_err);
    check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge HCLK);
      if (rsp_valid !== 1'b1 || rsp_err !== v.exp_err || rsp_rdata !== v.exp_rdata ||
          req_ready !== 1'b0 || psel !== '0) hold_ok = 0;
    end
    if (v.hold > 0) check({tag, "_hold_stable"}, hold_ok, 1);
    rsp_ready = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int  nacc;
    bit  tmo_seen;
    int  n;

    //        addr          wdata         wr  wt srdata        err hold sel      eerr erdata        lat
    vecs[0] = '{32'h1A10_1004, 32'hDEAD_BEEF, 1, 0, 32'h0000_0077, 0, 0, 9'h002, 0, 32'h0000_0000, 3};
    vecs[1] = '{32'h1A10_3000, 32'h0,         0, 3, 32'h1234_5678, 0, 0, 9'h008, 0, 32'h1234_5678, 6};
    vecs[2] = '{32'h1A10_9000, 32'h0,         0, 0, 32'h0,         0, 0, 9'h000, 1, 32'h0000_0000, 1};
    vecs[3] = '{32'h1A0F_FFFC, 32'h0,         0, 0, 32'h0,         0, 2, 9'h000, 1, 32'h0000_0000, 1};
    vecs[4] = '{32'h1A10_5000, 32'hCAFE_F00D, 1, 0, 32'h0000_0055, 1, 5, 9'h020, 1, 32'h0000_0000, 3};
    vecs[5] = '{32'h1A10_8FFC, 32'h0,         0, 1, 32'hA5A5_5A5A, 0, 0, 9'h100, 0, 32'hA5A5_5A5A, 4};
    vecs[6] = '{32'h1A10_0000, 32'h0,         0, 0, 32'h0000_0001, 0, 0, 9'h001, 0, 32'h0000_0001, 3};
    vecs[7] = '{32'h1A10_2010, 32'h0,         0, 2, 32'h1111_2222, 1, 0, 9'h004, 1, 32'h0000_0000, 5};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0,         0, 0, 32'h0,         0, 0, 9'h000, 1, 32'h0000_0000, 1};

    // Reset values while HRESETn is held low.
    repeat (3) @(negedge HCLK);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
    check("reset_apb_ctrl", {psel, penable, pwrite, timeout_o}, '0);
    check("reset_apb_data", {paddr, pwdata}, '0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Slave 2 never ready.
    req_valid = 1'b1;
    req_addr  = 32'h1A10_2000;
    req_write = 1'b0;
    set_slaves(2, 1'b0, 1'b0, 32'h5555_5555);
    @(posedge HCLK);
    @(negedge HCLK);
    req_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    nacc = 0;
    tmo_seen = 0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (psel == 9'h004 && penable) nacc++;
      if (timeout_o) tmo_seen = 1;
      @(negedge HCLK);
      n++;
    end
    check("tmo_access_cycles", nacc, 8);
    check("tmo_early_pulse", tmo_seen, 0);
    check("tmo_pulse", timeout_o, 1);
    check("tmo_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    rsp_ready = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    rsp_ready = 1'b0;
    check("tmo_pulse_end", {timeout_o, rsp_valid}, 2'b00);
    // Start another stalled transfer to be cut by reset.
    req_valid = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    req_valid = 1'b0;
    repeat (3) @(negedge HCLK);
`else
    nacc = 0;
    tmo_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      if (psel == 9'h004 && penable) nacc++;
      if (timeout_o || rsp_valid) tmo_seen = 1;
      @(negedge HCLK);
    end
    check("stall_access_cycles", nacc, 999);
    check("stall_no_rsp", tmo_seen, 0);
    check("stall_still_access", {psel, penable, rsp_valid}, {9'h004, 1'b1, 1'b0});
`endif
    check("pre_reset_access", {psel, penable}, {9'h004, 1'b1});

    // Asynchronous reset in the middle of ACCESS.
    HRESETn = 1'b0;
    #1;
    check("async_reset_drop", {psel, penable, rsp_valid, req_ready}, '0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    run_vec(vecs[6], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
